seq_div: RTL
============

# seq_div

Parametrised multi-cycle integer divider for the multdiv unit. It performs one restoring shift-subtract iteration per clock and supports signed and unsigned modes selected per operation. It returns both quotient and remainder, flags divide-by-zero, and uses the same ctrl_DIV start pulse and data_resultRDY completion pulse as the existing multiply/divide datapath.

## Interface
- WIDTH, default 32: operand/result width in bits; legal range 4..64.
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous active-low reset.
- data_operandA  input  WIDTH  dividend; sampled only on the clock edge where ctrl_DIV=1.
- data_operandB  input  WIDTH  divisor; sampled with A.
- ctrl_DIV  input  1  start pulse; one cycle high starts an operation.
- ctrl_SIGNED  input  1  sampled with the operands; 1 selects two's-complement, 0 selects unsigned.
- data_result  output  WIDTH  quotient, held from the data_resultRDY pulse until the next start.
- data_remainder  output  WIDTH  remainder, held like data_result.
- data_exception  output  1  divide-by-zero flag, held like data_result.
- data_resultRDY  output  1  one-cycle completion pulse.
- data_busy  output  1  high while an operation is in flight.

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE + ctrl_DIV=1:
  - Latch the operand magnitudes (negate an operand if signed mode and its MSB is set).
  - Latch the quotient sign (A[MSB] XOR B[MSB]) and the remainder sign (A[MSB]). Both signs are forced to 0 in unsigned mode.
  - Clear the partial remainder and load the iteration counter with WIDTH.
  - If B==0, go to DONE. Otherwise go to RUN.
- RUN, each cycle:
  - Shift {partial remainder, quotient} left by 1.
  - Trial-subtract the divisor magnitude from the partial remainder in WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient LSB=1. Otherwise restore and set LSB=0.
  - Decrement the counter. Leave RUN for FIX after exactly WIDTH iterations.
- FIX: negate the quotient if the quotient sign is set and the remainder if the remainder sign is set, then register both to the outputs. Go to DONE.
- DONE: assert data_resultRDY for this cycle only, then go to IDLE.
- Division truncates toward zero. The remainder takes the sign of the dividend, and quotient*B + remainder == A for every non-zero B.
- Divide by zero: data_exception=1, data_result=0, data_remainder=A as supplied, data_resultRDY pulses as normal.
- Signed overflow (A = most-negative value, B = -1): data_result = most-negative value, data_remainder=0, data_exception=0. This wrap is not an exception.
- ctrl_DIV=1 while busy (RUN, FIX or DONE): abort the current operation with no RDY pulse for it, and restart with the new operands as if from IDLE.
- Outputs stay stable while busy and change only on the FIX edge, or on the start edge for divide by zero. data_exception clears on the next start edge.
- Unsigned magnitudes use the full WIDTH bits, so the partial remainder needs WIDTH+1 bits.

## Timing
- Reset (asynchronous, any state) forces:
  - state IDLE;
  - data_result, data_remainder, data_exception, data_resultRDY and data_busy all 0;
  - the counter cleared.
  - An operation interrupted by reset never produces a RDY pulse.
- Edge numbering: ctrl_DIV is sampled high at edge 0.
- Normal operation:
  - data_busy=1 from edge 0.
  - RUN occupies edges 1..WIDTH and FIX is at edge WIDTH+1.
  - data_resultRDY is high from edge WIDTH+1 to edge WIDTH+2, i.e. a latency of WIDTH+2 cycles (34 for WIDTH=32).
  - data_busy falls at edge WIDTH+2.
- Divide by zero: outputs update at edge 0, RDY is high for the cycle after edge 1, and busy falls at edge 2.
- A ctrl_DIV sampled in the same cycle that RDY is high is accepted as a restart. The completed result's RDY pulse has already been issued and is not lost.
- Back-to-back throughput: one result every WIDTH+2 cycles.

## Test plan
- WIDTH=32, unsigned, A=100, B=7 → quotient 14, remainder 2; RDY exactly 34 cycles after start and high for 1 cycle; busy high for the 34 cycles in between.
- WIDTH=32, signed, A=-7, B=2 → quotient -3 (0xFFFFFFFD), remainder -1. Unsigned A=0xFFFFFFF9, B=2 → quotient 0x7FFFFFFC, remainder 1.
- B=0, A=0x1234 → exception=1, result 0, remainder 0x1234, RDY 2 cycles after start. The next valid divide clears the exception.
- WIDTH=8, signed, A=0x80, B=0xFF → result 0x80, remainder 0, exception 0, RDY at cycle 10. Also run random signed/unsigned pairs checked against a reference model.
- Restart: start 1000/3, reassert ctrl_DIV at cycle 10 with 50/5 → no RDY for the first divide; RDY 34 cycles after the second start with quotient 10, remainder 0.
- Reset: assert reset_n=0 mid-RUN, asynchronously between clock edges → all outputs 0 immediately, no RDY. After release, a fresh 9/4 divide returns quotient 2, remainder 1.

Source files
------------

// File: rtl/seq_div.sv
// rtl/seq_div.sv - multi-cycle restoring divider, signed/unsigned, quotient + remainder
// One shift-subtract step per clock; divide-by-zero short-circuits straight to DONE.
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        state_d     = state_q;
        prem_d      = prem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;

        a_neg   = ctrl_SIGNED & data_operandA[WIDTH-1];
        b_neg   = ctrl_SIGNED & data_operandB[WIDTH-1];
        a_mag   = a_neg ? -data_operandA : data_operandA;
        b_mag   = b_neg ? -data_operandB : data_operandB;
        // The shifted-in remainder can reach 2*divisor-1, hence one extra bit.
        shifted = {prem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, div_q};

        case (state_q)
            RUN: begin
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    quo_d  = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = q_neg_q ? -quo_q : quo_q;
                remainder_d = r_neg_q ? -prem_q : prem_q;
                rdy_d       = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                // Divide-by-zero enters DONE with RDY still low and spends one extra cycle here.
                if (rdy_q) begin
                    state_d = IDLE;
                end else begin
                    rdy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ctrl_DIV) begin
            rdy_d   = 1'b0;
            prem_d  = '0;
            quo_d   = a_mag;
            div_d   = b_mag;
            cnt_d   = CNT_LOAD;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            exc_d   = (data_operandB == '0);
            if (data_operandB == '0) begin
                result_d    = '0;
                remainder_d = data_operandA;
                state_d     = DONE;
            end else begin
                state_d = RUN;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prem_q      <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            prem_q      <= prem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
            busy_q      <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign data_busy      = busy_q;

endmodule
